pcie_tx_arbiter: RTL and testbench
==================================

PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 SHALL have parameter BUF_AV_MIN, default 6'd2: minimum tx_buf_av needed to start a packet.
REQ-002 SHALL have port clk, input, 1: user clock (user_clk_out of the PCIe core).
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_rq0_tdata/tkeep/tuser, input, 32/4/4: requester 0 stream (completion engine).
REQ-005 SHALL have port i_rq0_tlast/tvalid, input, 1/1: requester 0 framing.
REQ-006 SHALL have port o_rq0_tready, output, 1: requester 0 accept.
REQ-007 SHALL have ports i_rq1_* / o_rq1_tready, identical to REQ-004..006: requester 1 (memory write engine).
REQ-008 SHALL have port s_axis_tx_tdata/tkeep/tuser, output, 32/4/4: to core TX.
REQ-009 SHALL have port s_axis_tx_tlast/tvalid, output, 1/1: to core TX.
REQ-010 SHALL have port s_axis_tx_tready, input, 1: core TX accept.
REQ-011 SHALL have port tx_buf_av, input, 6: core free TX buffers.
REQ-012 SHALL have port tx_cfg_req, input, 1: core requests TX slot for config TLP.
REQ-013 SHALL have port tx_cfg_gnt, output, 1: grant to core.
REQ-014 SHALL have port tx_err_drop, input, 1: core dropped a TLP.
REQ-015 SHALL have port o_drop_count, output, 16: dropped-TLP counter.
REQ-016 SHALL have port o_busy, output, 1: high when state != IDLE.

Function
REQ-017 SHALL implement states IDLE, CFG, GNT0, GNT1 (registered).
REQ-018 IDLE: tx_cfg_req=1 -> CFG (highest priority, checked first).
REQ-019 IDLE, no cfg req, tx_buf_av >= BUF_AV_MIN, some i_rqN_tvalid -> GNT0/GNT1 by round-robin.
REQ-020 Round-robin: register last_gnt (reset 1, i.e. rq0 preferred first); both valid -> grant the requester != last_gnt; one valid -> grant it; last_gnt updates on entry to GNTx.
REQ-021 tx_buf_av < BUF_AV_MIN in IDLE -> stay IDLE, no grant, even with valid requests.
REQ-022 GNTx: s_axis_tx_* = i_rqx_* combinationally (zero latency); o_rqx_tready = s_axis_tx_tready; other requester tready = 0.
REQ-023 GNTx -> IDLE on beat with tvalid & tready & tlast; no return without that beat (tx_buf_av and tx_cfg_req ignored mid-packet).
REQ-024 One IDLE (arbitration) cycle SHALL separate consecutive packets; back-to-back packet throughput = N+1 cycles per N-beat packet.
REQ-025 IDLE/CFG: s_axis_tx_tvalid = 0, tlast = 0, tdata/tkeep/tuser = 0; both o_rqN_tready = 0.
REQ-026 tx_cfg_gnt SHALL be registered, 1 only while in CFG; CFG -> IDLE when tx_cfg_req = 0 (gnt falls one cycle after req falls).
REQ-027 o_drop_count SHALL increment by 1 per cycle with tx_err_drop = 1, saturating at 16'hFFFF.
REQ-028 Requester deasserting tvalid mid-packet SHALL keep grant; output tvalid follows it (bubble passes through).

Reset
REQ-029 rst_n = 0 SHALL asynchronously force state IDLE, last_gnt = 1, tx_cfg_gnt = 0, o_drop_count = 0, o_busy = 0; all s_axis_tx_* and o_rqN_tready therefore 0.
REQ-030 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from IDLE with rq0 preferred.

Verification
REQ-031 Single: rq0 4-beat packet, tready=1, tx_buf_av=10 -> GNT0 entered 1 cycle after tvalid, 4 beats forwarded unchanged, IDLE after tlast beat.
REQ-032 Fairness: both requesters continuously valid with 2-beat packets -> grant order rq0, rq1, rq0, rq1; each packet 3 cycles.
REQ-033 Buffer gate: tx_buf_av=1, rq1 valid -> no tvalid for 20 cycles; tx_buf_av=2 -> GNT1 next cycle.
REQ-034 Config: tx_cfg_req rises during rq0 3-beat packet -> packet completes, then tx_cfg_gnt=1; req falls -> gnt=0 next cycle, then pending rq1 granted.
REQ-035 Backpressure: s_axis_tx_tready toggled 1,0,1,0 during 3-beat packet -> o_rq0_tready mirrors it, no beat lost or duplicated.
REQ-036 Reset/counter: tx_err_drop pulsed 5 times -> o_drop_count=5; rst_n low mid-packet -> all outputs 0 immediately, count=0.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Two-requester AXI-Stream arbiter in front of the PCIe core TX port, with a
// config-TLP slot handshake toward the core and a saturating dropped-TLP counter.
module pcie_tx_arbiter #(
  parameter logic [5:0] BUF_AV_MIN = 6'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_rq0_tdata,
  input  logic [3:0]  i_rq0_tkeep,
  input  logic [3:0]  i_rq0_tuser,
  input  logic        i_rq0_tlast,
  input  logic        i_rq0_tvalid,
  output logic        o_rq0_tready,
  input  logic [31:0] i_rq1_tdata,
  input  logic [3:0]  i_rq1_tkeep,
  input  logic [3:0]  i_rq1_tuser,
  input  logic        i_rq1_tlast,
  input  logic        i_rq1_tvalid,
  output logic        o_rq1_tready,
  output logic [31:0] s_axis_tx_tdata,
  output logic [3:0]  s_axis_tx_tkeep,
  output logic [3:0]  s_axis_tx_tuser,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_cfg_req,
  output logic        tx_cfg_gnt,
  input  logic        tx_err_drop,
  output logic [15:0] o_drop_count,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, CFG, GNT0, GNT1} state_t;

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        cfg_gnt_q, cfg_gnt_d;
  logic        busy_q, busy_d;
  logic [15:0] drop_count_q, drop_count_d;

  // A beat transfers on a cycle with tvalid & tready both high; tvalid never
  // depends on tready, and the granted requester sees the core's tready as-is.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (tx_cfg_req) begin
          state_d = CFG;
        end else if (tx_buf_av >= BUF_AV_MIN) begin
          if (i_rq0_tvalid && (!i_rq1_tvalid || last_gnt_q)) begin
            state_d    = GNT0;
            last_gnt_d = 1'b0;
          end else if (i_rq1_tvalid) begin
            state_d    = GNT1;
            last_gnt_d = 1'b1;
          end
        end
      end
      CFG: begin
        if (!tx_cfg_req) state_d = IDLE;
      end
      GNT0: begin
        if (i_rq0_tvalid && s_axis_tx_tready && i_rq0_tlast) state_d = IDLE;
      end
      GNT1: begin
        if (i_rq1_tvalid && s_axis_tx_tready && i_rq1_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cfg_gnt_d = (state_d == CFG);
    busy_d    = (state_d != IDLE);
    drop_count_d = drop_count_q;
    if (tx_err_drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      cfg_gnt_q    <= 1'b0;
      busy_q       <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      cfg_gnt_q    <= cfg_gnt_d;
      busy_q       <= busy_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Zero-latency pass-through of the granted requester; everything idles at 0.
  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tuser  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    o_rq0_tready     = 1'b0;
    o_rq1_tready     = 1'b0;
    case (state_q)
      GNT0: begin
        s_axis_tx_tdata  = i_rq0_tdata;
        s_axis_tx_tkeep  = i_rq0_tkeep;
        s_axis_tx_tuser  = i_rq0_tuser;
        s_axis_tx_tlast  = i_rq0_tlast;
        s_axis_tx_tvalid = i_rq0_tvalid;
        o_rq0_tready     = s_axis_tx_tready;
      end
      GNT1: begin
        s_axis_tx_tdata  = i_rq1_tdata;
        s_axis_tx_tkeep  = i_rq1_tkeep;
        s_axis_tx_tuser  = i_rq1_tuser;
        s_axis_tx_tlast  = i_rq1_tlast;
        s_axis_tx_tvalid = i_rq1_tvalid;
        o_rq1_tready     = s_axis_tx_tready;
      end
      default: ;
    endcase
  end

  assign tx_cfg_gnt   = cfg_gnt_q;
  assign o_busy       = busy_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: per-cycle comparison against an ownership model,
// per-requester beat queues, and hand-timed checks of grant order and latency.
module tb_pcie_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_rq0_tdata, i_rq1_tdata;
  logic [3:0]  i_rq0_tkeep, i_rq1_tkeep, i_rq0_tuser, i_rq1_tuser;
  logic        i_rq0_tlast, i_rq1_tlast, i_rq0_tvalid, i_rq1_tvalid;
  logic        o_rq0_tready, o_rq1_tready;
  logic [31:0] s_axis_tx_tdata;
  logic [3:0]  s_axis_tx_tkeep, s_axis_tx_tuser;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
  logic [5:0]  tx_buf_av;
  logic        tx_cfg_req, tx_cfg_gnt, tx_err_drop;
  logic [15:0] o_drop_count;
  logic        o_busy;

  pcie_tx_arbiter #(.BUF_AV_MIN(6'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rq0_tdata(i_rq0_tdata), .i_rq0_tkeep(i_rq0_tkeep), .i_rq0_tuser(i_rq0_tuser),
    .i_rq0_tlast(i_rq0_tlast), .i_rq0_tvalid(i_rq0_tvalid), .o_rq0_tready(o_rq0_tready),
    .i_rq1_tdata(i_rq1_tdata), .i_rq1_tkeep(i_rq1_tkeep), .i_rq1_tuser(i_rq1_tuser),
    .i_rq1_tlast(i_rq1_tlast), .i_rq1_tvalid(i_rq1_tvalid), .o_rq1_tready(o_rq1_tready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
    .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
    .tx_err_drop(tx_err_drop), .o_drop_count(o_drop_count), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- counters and logs ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  int first_cyc[$];
  int last_cyc[$];
  logic [7:0] last_tag[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_logs();
    first_cyc.delete();
    last_cyc.delete();
    last_tag.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Beat word layout: {tlast, tuser, tkeep, tdata}; tdata = {A0+id, pkt, beat, 5A}.
  function automatic logic [40:0] beat_word(input int id, input int pkt, input int b, input int nb);
    logic [31:0] d;
    logic [3:0]  k, u;
    logic        l;
    d = {8'hA0 + 8'(id), 8'(pkt), 8'(b), 8'h5A};
    l = (b == nb - 1);
    k = l ? 4'h3 : 4'hF;
    u = 4'(id * 8 + b);
    return {l, u, k, d};
  endfunction

  task automatic drive(input int id, input logic v, input logic [40:0] w);
    if (id == 0) begin
      i_rq0_tvalid = v;
      {i_rq0_tlast, i_rq0_tuser, i_rq0_tkeep, i_rq0_tdata} = w;
    end else begin
      i_rq1_tvalid = v;
      {i_rq1_tlast, i_rq1_tuser, i_rq1_tkeep, i_rq1_tdata} = w;
    end
  endtask

  // Presents nb beats; an optional one-cycle tvalid bubble precedes beat bubble_at.
  task automatic send_pkt(input int id, input int nb, input int pkt, input int bubble_at);
    logic acc;
    int   t;
    for (int b = 0; b < nb; b++) begin
      if (id == 0) exp_q0.push_back(beat_word(id, pkt, b, nb));
      else         exp_q1.push_back(beat_word(id, pkt, b, nb));
    end
    for (int b = 0; b < nb; b++) begin
      if (b == bubble_at) begin
        drive(id, 1'b0, '0);
        @(posedge clk); #1;
      end
      drive(id, 1'b1, beat_word(id, pkt, b, nb));
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = (id == 0) ? (i_rq0_tvalid && o_rq0_tready) : (i_rq1_tvalid && o_rq1_tready);
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        chk("driver_timeout", 64'd0, 64'd1);
        drive(id, 1'b0, '0);
        return;
      end
    end
    drive(id, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- model + scoreboard ----------------
  // Ownership of the TX port: -1 free, 2 config slot, 0/1 requester.
  int          m_own  = -1;
  int          m_pref = 0;
  logic [15:0] m_drops = '0;

  always @(negedge clk) begin : compare
    logic [40:0] in0, in1, act_w, exp_w, got;
    logic        ev, er0, er1, v0, v1, fin;
    int          pick;
    in0   = {i_rq0_tlast, i_rq0_tuser, i_rq0_tkeep, i_rq0_tdata};
    in1   = {i_rq1_tlast, i_rq1_tuser, i_rq1_tkeep, i_rq1_tdata};
    act_w = {s_axis_tx_tlast, s_axis_tx_tuser, s_axis_tx_tkeep, s_axis_tx_tdata};
    v0    = i_rq0_tvalid;
    v1    = i_rq1_tvalid;
    if (!rst_n) begin
      m_own   = -1;
      m_pref  = 0;
      m_drops = '0;
    end
    exp_w = '0; ev = 1'b0; er0 = 1'b0; er1 = 1'b0;
    if (m_own == 0) begin
      exp_w = in0; ev = v0; er0 = s_axis_tx_tready;
    end else if (m_own == 1) begin
      exp_w = in1; ev = v1; er1 = s_axis_tx_tready;
    end
    chk("tx_tvalid", 64'(s_axis_tx_tvalid), 64'(ev));
    chk("tx_beat", 64'(act_w), 64'(exp_w));
    chk("rq0_tready", 64'(o_rq0_tready), 64'(er0));
    chk("rq1_tready", 64'(o_rq1_tready), 64'(er1));
    chk("cfg_gnt", 64'(tx_cfg_gnt), 64'(m_own == 2));
    chk("busy", 64'(o_busy), 64'(m_own != -1));
    chk("drop_count", 64'(o_drop_count), 64'(m_drops));
    if (rst_n) begin
      if (s_axis_tx_tvalid && s_axis_tx_tready) begin
        got = '0;
        if (m_own == 0 && exp_q0.size() > 0) got = exp_q0.pop_front();
        else if (m_own == 1 && exp_q1.size() > 0) got = exp_q1.pop_front();
        chk("sb_beat", 64'(act_w), 64'(got));
        if (s_axis_tx_tdata[15:8] == 8'd0) first_cyc.push_back(cyc);
        if (s_axis_tx_tlast) begin
          last_cyc.push_back(cyc);
          last_tag.push_back(s_axis_tx_tdata[31:24]);
        end
      end
      fin = ev && s_axis_tx_tready && exp_w[40];
      if (m_own == -1) begin
        if (tx_cfg_req) m_own = 2;
        else if (tx_buf_av >= 6'd2 && (v0 || v1)) begin
          pick   = (v0 && v1) ? m_pref : (v0 ? 0 : 1);
          m_own  = pick;
          m_pref = 1 - pick;
        end
      end else if (m_own == 2) begin
        if (!tx_cfg_req) m_own = -1;
      end else if (fin) begin
        m_own = -1;
      end
      if (tx_err_drop && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    end
  end

  // ---------------- directed tests ----------------
  int c0, c_gate, gnt_cyc, rel, tw;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    s_axis_tx_tready = 1'b1;
    tx_buf_av   = 6'd10;
    tx_cfg_req  = 1'b0;
    tx_err_drop = 1'b0;
    #1;
    chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    chk("rst_cfg_gnt", 64'(tx_cfg_gnt), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_drops", 64'(o_drop_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 4-beat packet from rq0.
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    send_pkt(0, 4, 1, -1);
    chk("single_first", 64'(first_cyc[0]), 64'(c0 + 1));
    chk("single_last", 64'(last_cyc[0]), 64'(c0 + 4));
    chk("single_idle", 64'(o_busy), 64'd0);

    // Fairness from reset: both requesters hold two 2-beat packets each.
    do_reset();
    clr_logs();
    c0 = cyc;
    fork
      begin send_pkt(0, 2, 10, -1); send_pkt(0, 2, 11, -1); end
      begin send_pkt(1, 2, 20, -1); send_pkt(1, 2, 21, -1); end
    join
    chk("rr_order", 64'({last_tag[0], last_tag[1], last_tag[2], last_tag[3]}), 64'h00000000_A0A1A0A1);
    chk("rr_last0", 64'(last_cyc[0]), 64'(c0 + 2));
    chk("rr_last3", 64'(last_cyc[3]), 64'(c0 + 11));

    // Buffer gate: tx_buf_av below the minimum blocks a valid request.
    @(posedge clk); #1;
    clr_logs();
    tx_buf_av = 6'd1;
    fork
      send_pkt(1, 2, 30, -1);
      begin
        repeat (20) begin
          @(negedge clk);
          chk("gate_hold", 64'(s_axis_tx_tvalid), 64'd0);
        end
        @(posedge clk); #1;
        tx_buf_av = 6'd2;
        c_gate = cyc;
      end
    join
    chk("gate_first", 64'(first_cyc[0]), 64'(c_gate + 1));
    tx_buf_av = 6'd10;

    // Config request arrives mid-packet; rq1 waits behind the config slot.
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    fork
      send_pkt(0, 3, 40, -1);
      begin
        repeat (2) @(posedge clk);
        #1 tx_cfg_req = 1'b1;
        tw = 0;
        while (!tx_cfg_gnt && tw < 50) begin
          @(negedge clk);
          tw++;
        end
        gnt_cyc = cyc;
        repeat (3) @(posedge clk);
        #1 tx_cfg_req = 1'b0;
        rel = cyc;
        @(negedge clk);
        chk("cfg_gnt_hold", 64'(tx_cfg_gnt), 64'd1);
        @(negedge clk);
        chk("cfg_gnt_fall", 64'(tx_cfg_gnt), 64'd0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 send_pkt(1, 2, 41, -1);
      end
    join
    chk("cfg_pkt_last", 64'(last_cyc[0]), 64'(c0 + 3));
    chk("cfg_gnt_cyc", 64'(gnt_cyc), 64'(c0 + 5));
    chk("cfg_then_rq1", 64'(first_cyc[1]), 64'(rel + 2));
    chk("cfg_order", 64'({last_tag[0], last_tag[1]}), 64'h0000_0000_0000_A0A1);

    // Backpressure: core tready alternates 1,0,1,0,... during a 3-beat packet.
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    fork
      send_pkt(0, 3, 50, -1);
      begin
        for (int i = 0; i < 8; i++) begin
          s_axis_tx_tready = (i % 2 == 0);
          @(posedge clk); #1;
        end
        s_axis_tx_tready = 1'b1;
      end
    join
    chk("bp_first", 64'(first_cyc[0]), 64'(c0 + 2));
    chk("bp_last", 64'(last_cyc[0]), 64'(c0 + 6));
    chk("bp_pkts", 64'(last_cyc.size()), 64'd1);

    // Mid-packet tvalid bubble keeps the grant.
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    send_pkt(1, 3, 60, 1);
    chk("bubble_first", 64'(first_cyc[0]), 64'(c0 + 1));
    chk("bubble_last", 64'(last_cyc[0]), 64'(c0 + 4));

    // Drop counter, then reset in the middle of an rq0 packet.
    for (int i = 0; i < 5; i++) begin
      tx_err_drop = 1'b1;
      @(posedge clk); #1;
      tx_err_drop = 1'b0;
      @(posedge clk); #1;
    end
    chk("drops_5", 64'(o_drop_count), 64'd5);
    clr_logs();
    c0 = cyc;
    fork
      send_pkt(0, 4, 70, -1);
      begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
        chk("rst_mid_tready", 64'(o_rq0_tready), 64'd0);
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        chk("rst_mid_drops", 64'(o_drop_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #1 send_pkt(1, 1, 71, -1);
      end
    join
    chk("rst_pref_order", 64'({last_tag[0], last_tag[1]}), 64'h0000_0000_0000_A0A1);
    chk("rst_resume_last", 64'(last_cyc[0]), 64'(c0 + 6));

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
